// File: rtl/wb_pkg.sv
// Shared types and geometry for the dirty-line write-back buffer.
// The entry struct fixes the line geometry; the top-level width parameters
// default to these values and must stay equal to them.
package wb_pkg;

    localparam int WB_WR_PORTS = 2;
    localparam int WB_RD_PORTS = 2;
    localparam int WB_ADDR_W   = 13;
    localparam int WB_DATA_W   = 64;
    localparam int WB_DEPTH    = 4;

    // Pointer width wraps modulo depth (depth is a power of two).
    localparam int WB_PTR_W    = $clog2(WB_DEPTH);
    // Occupancy needs one extra code so that "full" is representable.
    localparam int WB_CNT_W    = $clog2(WB_DEPTH + 1);

    // One buffered dirty line.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_buffer_if.sv
// Bus bundle between the victim cache / core lookup side, the write-back
// buffer and the next memory level.
//
// Handshake semantics:
//   enqueue : an enq_valid bit is a one-cycle request; it is taken at the
//             clock edge only if enq_ready is 1 in that cycle. enq_ready
//             depends on registered occupancy only. A request while
//             enq_ready is 0 is dropped (the buffer flags overflow).
//   memory  : mem_req_valid/addr/data describe the head entry; a transfer
//             happens on the edge where mem_req_valid && mem_req_ready.
//             While valid is high and ready is low, addr/data hold stable.
//             mem_req_valid never depends combinationally on mem_req_ready.
//   lookup  : lk_hit/lk_data are purely combinational from lk_addr and the
//             registered buffer contents.
interface writeback_buffer_if #(
    parameter int WR_PORT_NUM = 2,
    parameter int RD_PORT_NUM = 2,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 64
);

    logic [WR_PORT_NUM-1:0]                 enq_valid;
    logic [WR_PORT_NUM-1:0][ADDR_WIDTH-1:0] enq_addr;
    logic [WR_PORT_NUM-1:0][DATA_WIDTH-1:0] enq_data;
    logic                                   enq_ready;

    logic [RD_PORT_NUM-1:0][ADDR_WIDTH-1:0] lk_addr;
    logic [RD_PORT_NUM-1:0]                 lk_hit;
    logic [RD_PORT_NUM-1:0][DATA_WIDTH-1:0] lk_data;

    logic                                   mem_req_valid;
    logic [ADDR_WIDTH-1:0]                  mem_req_addr;
    logic [DATA_WIDTH-1:0]                  mem_req_data;
    logic                                   mem_req_ready;

    // Requester side: victim cache, core lookups and memory-ready driver.
    modport master (
        output enq_valid, enq_addr, enq_data,
        input  enq_ready,
        output lk_addr,
        input  lk_hit, lk_data,
        input  mem_req_valid, mem_req_addr, mem_req_data,
        output mem_req_ready
    );

    // Buffer side.
    modport slave (
        input  enq_valid, enq_addr, enq_data,
        output enq_ready,
        input  lk_addr,
        output lk_hit, lk_data,
        output mem_req_valid, mem_req_addr, mem_req_data,
        input  mem_req_ready
    );

endinterface

// File: rtl/wb_lookup.sv
// Single lookup port: scans the occupied entries from head (oldest) to
// tail (youngest) and reports the youngest entry whose address matches.
module wb_lookup
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  wb_entry_t                    entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     head_i,
    input  logic [$clog2(DEPTH+1)-1:0]   count_i,
    input  logic [WB_ADDR_W-1:0]         addr_i,
    output logic                         hit_o,
    output logic [WB_DATA_W-1:0]         data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] idx;

    // Age-ordered scan: later (younger) matches overwrite earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if ((CNT_W'(k) < count_i) && (entries_i[idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Dirty-line write-back buffer. Captures evicted dirty lines from several
// write ports into a circular FIFO, drains the head to the next memory
// level one line per handshake, and keeps every queued line visible to
// combinational lookups so in-flight lines can still be forwarded.
module writeback_buffer
    import wb_pkg::*;
#(
    parameter int WR_PORT_NUM = WB_WR_PORTS,
    parameter int RD_PORT_NUM = WB_RD_PORTS,
    parameter int ADDR_WIDTH  = WB_ADDR_W,
    parameter int DATA_WIDTH  = WB_DATA_W,
    parameter int DEPTH       = WB_DEPTH   // power of two, >= WR_PORT_NUM
) (
    input  logic                         clk,
    input  logic                         rst_n,
    writeback_buffer_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Line storage; deliberately not reset (validity comes from count_q).
    wb_entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] n_enq;
    logic             enq_ready;
    logic             any_enq;
    logic             deq;

    logic [WR_PORT_NUM-1:0] wr_en;
    logic [PTR_W-1:0]       wr_idx [WR_PORT_NUM];

    logic [RD_PORT_NUM-1:0]                 lk_hit;
    logic [RD_PORT_NUM-1:0][DATA_WIDTH-1:0] lk_data;

    // Acceptance depends on registered occupancy only, so a same-cycle
    // dequeue can never open the door for an enqueue.
    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign enq_ready  = (free_slots >= CNT_W'(WR_PORT_NUM));
    assign any_enq    = |bus.enq_valid;
    assign deq        = (count_q != '0) && bus.mem_req_ready;

    // Compact the valid ports into consecutive slots starting at the tail,
    // lowest port index first; count how many are being written.
    always_comb begin
        n_enq = '0;
        wr_en = '0;
        for (int p = 0; p < WR_PORT_NUM; p++) begin
            wr_idx[p] = tail_q + PTR_W'(n_enq);
            wr_en[p]  = enq_ready && bus.enq_valid[p];
            if (bus.enq_valid[p]) begin
                n_enq = n_enq + CNT_W'(1);
            end
        end
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    // A rejected cycle drops every request of that cycle, not just some.
    always_comb begin
        head_d     = head_q + PTR_W'(deq);
        tail_d     = tail_q;
        count_d    = count_q - CNT_W'(deq);
        overflow_d = overflow_q;
        if (enq_ready) begin
            tail_d  = tail_q + PTR_W'(n_enq);
            count_d = count_q + n_enq - CNT_W'(deq);
        end else if (any_enq) begin
            overflow_d = 1'b1;
        end
    end

    // Control state; asynchronous reset discards everything, including a
    // head that is mid-handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Line storage writes; compaction guarantees distinct slots per port.
    always_ff @(posedge clk) begin
        for (int p = 0; p < WR_PORT_NUM; p++) begin
            if (wr_en[p]) begin
                mem_q[wr_idx[p]] <= '{addr: bus.enq_addr[p], data: bus.enq_data[p]};
            end
        end
    end

    // One youngest-match selector per lookup port.
    for (genvar r = 0; r < RD_PORT_NUM; r++) begin : g_lookup
        wb_lookup #(
            .DEPTH (DEPTH)
        ) u_lookup (
            .entries_i (mem_q),
            .head_i    (head_q),
            .count_i   (count_q),
            .addr_i    (bus.lk_addr[r]),
            .hit_o     (lk_hit[r]),
            .data_o    (lk_data[r])
        );
    end

    assign bus.enq_ready     = enq_ready;
    assign bus.lk_hit        = lk_hit;
    assign bus.lk_data       = lk_data;
    assign bus.mem_req_valid = (count_q != '0);
    assign bus.mem_req_addr  = mem_q[head_q].addr;
    assign bus.mem_req_data  = mem_q[head_q].data;

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed scenarios followed by random traffic,
// checked by a queue-level reference model and an output monitor.
module tb_writeback_buffer;
    import wb_pkg::*;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int W  = AW + DW;
    localparam int DEPTH_M = 4;
    localparam int WR_M    = 2;

    logic clk;
    logic rst_n;
    logic [WB_CNT_W-1:0] count;
    logic overflow;

    writeback_buffer_if #(
        .WR_PORT_NUM (2),
        .RD_PORT_NUM (2),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) bus ();

    writeback_buffer #(
        .WR_PORT_NUM (2),
        .RD_PORT_NUM (2),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEPTH       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .count    (count),
        .overflow (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];     // expected mem_req sequence
    logic [W-1:0] model_q[$];   // reference buffer contents, oldest first
    logic         ovf_m = 1'b0;
    logic [DW:0]  lr;
    int           m_free;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Youngest matching line in the reference contents; {hit, data}.
    function automatic logic [DW:0] lk_model(input logic [AW-1:0] a);
        logic [DW:0] r;
        r = '0;
        foreach (model_q[i]) begin
            if (model_q[i][W-1:DW] == a) r = {1'b1, model_q[i][DW-1:0]};
        end
        return r;
    endfunction

    // Reference model: a bounded FIFO with all-or-nothing acceptance judged
    // on the occupancy before the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            exp_q.delete();
            ovf_m <= 1'b0;
        end else begin
            m_free = DEPTH_M - model_q.size();
            if (model_q.size() != 0 && bus.mem_req_ready) void'(model_q.pop_front());
            if (bus.enq_valid != '0) begin
                if (m_free >= WR_M) begin
                    for (int p = 0; p < WR_M; p++) begin
                        if (bus.enq_valid[p]) begin
                            model_q.push_back({bus.enq_addr[p], bus.enq_data[p]});
                            exp_q.push_back({bus.enq_addr[p], bus.enq_data[p]});
                        end
                    end
                end else begin
                    ovf_m <= 1'b1;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", count, model_q.size());
            chk("mem_req_valid", bus.mem_req_valid, model_q.size() != 0);
            chk("enq_ready", bus.enq_ready, (DEPTH_M - model_q.size()) >= WR_M);
            chk("overflow", overflow, ovf_m);
            for (int r = 0; r < 2; r++) begin
                lr = lk_model(bus.lk_addr[r]);
                chk("lk_hit", bus.lk_hit[r], lr[DW]);
                chk("lk_data", bus.lk_data[r], lr[DW-1:0]);
            end
            if (bus.mem_req_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mem_head at %0t: got %h expected nothing", $time,
                             {bus.mem_req_addr, bus.mem_req_data});
                end else begin
                    chk("mem_head", {bus.mem_req_addr, bus.mem_req_data}, exp_q[0]);
                    if (bus.mem_req_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.enq_valid   = v;
        bus.enq_addr[0] = a0;
        bus.enq_data[0] = d0;
        bus.enq_addr[1] = a1;
        bus.enq_data[1] = d1;
        step();
        bus.enq_valid = '0;
    endtask

    task automatic drain();
        bus.mem_req_ready = 1'b1;
        repeat (6) step();
        bus.mem_req_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n             = 1'b0;
        bus.enq_valid     = '0;
        bus.enq_addr      = '0;
        bus.enq_data      = '0;
        bus.lk_addr       = '0;
        bus.mem_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_enq_ready", bus.enq_ready, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_valid", bus.mem_req_valid, 1'b0);
        chk("rst_lk_hit", bus.lk_hit, 2'b00);
        chk("rst_lk_data", bus.lk_data[0], 0);
        chk("rst_overflow", overflow, 1'b0);

        // Two-port enqueue, head held while memory stalls.
        enq(2'b11, 13'h0A1, 64'h11, 13'h0A2, 64'h22);
        chk("t1_count", count, 2);
        chk("t1_addr", bus.mem_req_addr, 13'h0A1);
        chk("t1_data", bus.mem_req_data, 64'h11);
        repeat (5) begin
            step();
            chk("t1_hold_addr", bus.mem_req_addr, 13'h0A1);
        end
        bus.mem_req_ready = 1'b1;
        step();
        chk("t1_next_addr", bus.mem_req_addr, 13'h0A2);
        chk("t1_next_data", bus.mem_req_data, 64'h22);
        step();
        chk("t1_empty", count, 0);
        bus.mem_req_ready = 1'b0;

        // Fill to three, then an enqueue while not ready is dropped.
        enq(2'b11, 13'h301, 64'h31, 13'h302, 64'h32);
        enq(2'b01, 13'h303, 64'h33, 13'h000, 64'h0);
        chk("t2_not_ready", bus.enq_ready, 1'b0);
        bus.mem_req_ready = 1'b1;
        enq(2'b01, 13'h304, 64'h34, 13'h000, 64'h0);
        bus.mem_req_ready = 1'b0;
        chk("t2_count", count, 2);
        chk("t2_overflow", overflow, 1'b1);
        step();
        chk("t2_overflow_sticky", overflow, 1'b1);
        drain();

        // Youngest-match lookup and miss.
        enq(2'b01, 13'h055, 64'hAA, 13'h000, 64'h0);
        enq(2'b01, 13'h055, 64'hBB, 13'h000, 64'h0);
        bus.lk_addr[0] = 13'h055;
        bus.lk_addr[1] = 13'h056;
        #1;
        chk("t3_hit", bus.lk_hit[0], 1'b1);
        chk("t3_data", bus.lk_data[0], 64'hBB);
        chk("t3_miss_hit", bus.lk_hit[1], 1'b0);
        chk("t3_miss_data", bus.lk_data[1], 0);
        drain();

        // No same-cycle forwarding of an enqueue into lookup.
        bus.lk_addr[0]  = 13'h100;
        bus.enq_valid   = 2'b01;
        bus.enq_addr[0] = 13'h100;
        bus.enq_data[0] = 64'hDEAD_BEEF;
        #1;
        chk("t4_same_cycle", bus.lk_hit[0], 1'b0);
        step();
        bus.enq_valid = '0;
        chk("t4_next_cycle", bus.lk_hit[0], 1'b1);
        chk("t4_next_data", bus.lk_data[0], 64'hDEAD_BEEF);
        drain();

        // Streaming pairs wrap the pointers.
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq(2'b01, 13'(13'h200 + i), {$urandom, $urandom}, 13'h000, 64'h0);
        end
        drain();

        // Random traffic with frequent stalls and overflows.
        for (int i = 0; i < 400; i++) begin
            bus.enq_valid     = 2'($urandom_range(0, 3));
            bus.enq_addr[0]   = 13'($urandom_range(0, 15));
            bus.enq_addr[1]   = 13'($urandom_range(0, 15));
            bus.enq_data[0]   = {$urandom, $urandom};
            bus.enq_data[1]   = {$urandom, $urandom};
            bus.lk_addr[0]    = 13'($urandom_range(0, 15));
            bus.lk_addr[1]    = 13'($urandom_range(0, 15));
            bus.mem_req_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        bus.enq_valid = '0;
        drain();

        // Asynchronous reset in the middle of a stalled transfer.
        bus.lk_addr[0] = 13'h0777;
        enq(2'b11, 13'h777, 64'h77, 13'h778, 64'h78);
        chk("t6_pre_valid", bus.mem_req_valid, 1'b1);
        chk("t6_pre_hit", bus.lk_hit[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid_drop", bus.mem_req_valid, 1'b0);
        chk("t6_count_drop", count, 0);
        chk("t6_hit_drop", bus.lk_hit[0], 1'b0);
        chk("t6_overflow_clr", overflow, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t6_after_count", count, 0);
        chk("t6_after_ready", bus.enq_ready, 1'b1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Dirty-line write-back buffer sitting directly downstream of the victim cache. It captures lines the victim cache evicts with `evict && evicted_dirty` on any of its write ports, queues them in FIFO order, and drains them one per handshake to the next memory level. Its contents remain visible to combinational lookups, so a line in flight to memory can still be forwarded to the core on a cache/victim miss.

## Interface
- `WR_PORT_NUM`, 2: enqueue ports; matches the victim cache write-port count.
- `RD_PORT_NUM`, 2: lookup ports; matches the victim cache read-port count.
- `ADDR_WIDTH`, 13: cache-line address width.
- `DATA_WIDTH`, 64: cache-line width.
- `DEPTH`, 4: entries; power of two, at least `WR_PORT_NUM`.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enq_valid`  in  [WR_PORT_NUM]  per-port enqueue request; driven from `evict & evicted_dirty`.
- `enq_addr`  in  [WR_PORT_NUM][ADDR_WIDTH]  evicted line address.
- `enq_data`  in  [WR_PORT_NUM][DATA_WIDTH]  evicted line data.
- `enq_ready`  out  1  at least `WR_PORT_NUM` entries free.
- `lk_addr`  in  [RD_PORT_NUM][ADDR_WIDTH]  lookup address.
- `lk_hit`  out  [RD_PORT_NUM]  address present in buffer.
- `lk_data`  out  [RD_PORT_NUM][DATA_WIDTH]  youngest matching data; 0 on miss.
- `mem_req_valid`  out  1  head entry is valid.
- `mem_req_addr`  out  ADDR_WIDTH  head address.
- `mem_req_data`  out  DATA_WIDTH  head data.
- `mem_req_ready`  in  1  memory accepts head.
- `count`  out  $clog2(DEPTH+1)  occupied entries.
- `overflow`  out  1  sticky error flag.

## Operation
- Circular FIFO with head/tail pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH. `count` is held explicitly.
- Enqueue:
  - Ports with `enq_valid=1` are written in port-index order, compacted: port 0 first, then port 1, and so on.
  - `count` increases by the number of valid ports.
  - No coalescing. Duplicate addresses, both within one cycle and against existing entries, are stored as separate entries.
- `enq_ready = (DEPTH - count) >= WR_PORT_NUM`. It is computed from registered `count` only; a same-cycle dequeue does not raise it.
- Overflow:
  - Any `enq_valid` while `enq_ready=0` drops all of that cycle's enqueues.
  - The same cycle sets `overflow`, which holds until reset.
- Dequeue:
  - `mem_req_valid = (count != 0)`. Addr and data come from the head entry.
  - On `mem_req_valid && mem_req_ready`, head advances by 1 and `count` decrements.
  - Enqueue and dequeue in the same cycle are both applied: `count_next = count + n_enq - deq`.
- Lookup:
  - Purely combinational against registered valid entries.
  - When several entries match, the youngest (closest to tail) wins.
  - The head is still visible during its dequeue cycle.
  - Same-cycle enqueues are not visible (no forwarding).
- Reset (asynchronous, may arrive mid-transfer):
  - Pointers, `count`, and `overflow` clear to 0.
  - `mem_req_valid` and `lk_hit` drop immediately.
  - A partially handshaked head is discarded.
  - Data/address storage is not reset.

## Timing
- Reset values:
  - `enq_ready=1`.
  - `mem_req_valid=0`, `mem_req_addr` and `mem_req_data` undefined but masked by valid.
  - `lk_hit=0`, `lk_data=0`, `count=0`, `overflow=0`.
- Enqueue accepted at edge N. The entry appears on `mem_req_*` at N+1 if the buffer was empty, and is visible to lookup from N+1.
- While `mem_req_valid=1` and `mem_req_ready=0`, `mem_req_addr` and `mem_req_data` are held stable.
- Throughput: one dequeue per cycle and up to `WR_PORT_NUM` enqueues per cycle.
- `enq_ready` and `count` are registered-state functions. There is no combinational path from `mem_req_ready` to `enq_ready`.

## Structure
- Package `wb_pkg`:
  - `wb_entry_t` struct {addr, data}.
  - `WB_PTR_W` / `WB_CNT_W` localparam helpers.
- One sub-module, `wb_lookup`: per-lookup-port youngest-match priority select over DEPTH entries, ordered relative to head. It is instantiated RD_PORT_NUM times.

## Test plan
- Reset, then enqueue port0 `0x0A1`/`0x11`, port1 `0x0A2`/`0x22` with `mem_req_ready=0`. Required response:
  - next cycle `count=2`, `mem_req_addr=0x0A1` and held stable for 5 cycles;
  - release ready; `0x0A2` follows one cycle later;
  - `count` reaches 0.
- Fill to 3 entries. Required response:
  - `enq_ready=0`;
  - enqueue one entry with `mem_req_ready=1` in the same cycle: entry dropped, `overflow=1` sticky;
  - `count` becomes 2.
- Enqueue `0x055`/`0xAA` then `0x055`/`0xBB`; lookup `0x055` -> `lk_hit=1`, `lk_data=0xBB`. Lookup `0x056` -> `lk_hit=0`, `lk_data=0`.
- Same-cycle enqueue of `0x100` plus lookup of `0x100` -> `lk_hit=0`; next cycle `lk_hit=1`.
- Run 10 enqueue/dequeue pairs with ready=1 to wrap pointers twice -> FIFO order preserved, `count` never exceeds 4.
- Assert `rst_n=0` mid-cycle while `mem_req_valid=1` and ready=0 -> `mem_req_valid=0` and `count=0` immediately, with no clock edge needed.
